// File: rtl/timer_ctrl_if.sv
// Host/counter-side signal bundle for timer_ctrl: configuration, interrupt
// handshake, and the control/observe lines of the external up-counter.
interface timer_ctrl_if #(
  parameter int WIDTH          = 16,
  parameter int PRESCALE_WIDTH = 8
);
  logic                      cfg_we;
  logic [WIDTH-1:0]          cfg_compare;
  logic [PRESCALE_WIDTH-1:0] cfg_prescale;
  logic                      cfg_mode;
  logic                      cfg_start;
  logic                      cfg_stop;
  logic                      irq_ack;
  logic [WIDTH-1:0]          cnt_val;
  logic                      cnt_en;
  logic                      cnt_clear;
  logic                      irq;
  logic                      irq_overrun;
  logic                      busy;
  logic [1:0]                state;

  modport master (
    output cfg_we, cfg_compare, cfg_prescale, cfg_mode,
    output cfg_start, cfg_stop, irq_ack, cnt_val,
    input  cnt_en, cnt_clear, irq, irq_overrun, busy, state
  );

  modport slave (
    input  cfg_we, cfg_compare, cfg_prescale, cfg_mode,
    input  cfg_start, cfg_stop, irq_ack, cnt_val,
    output cnt_en, cnt_clear, irq, irq_overrun, busy, state
  );
endinterface

// File: rtl/timer_ctrl.sv
// Interval-timer controller: prescaled ticks drive an external up-counter,
// compare match raises a level interrupt (one-shot or periodic) with overrun.
module timer_ctrl #(
  parameter int WIDTH          = 16,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic         clk,
  input  logic         rstn,
  timer_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [PRESCALE_WIDTH-1:0] PSC_ONE = PRESCALE_WIDTH'(1);

  state_t                    r_state;
  logic [WIDTH-1:0]          r_compare;
  logic [PRESCALE_WIDTH-1:0] r_prescale;
  logic [PRESCALE_WIDTH-1:0] r_psc;
  logic                      r_mode;
  logic                      r_irq;
  logic                      r_overrun;

  logic w_run;
  logic w_tick;
  logic w_match;
  logic w_start_accept;
  logic w_stop_accept;

  assign w_run          = (r_state == ST_RUN);
  assign w_tick         = w_run && (r_psc == r_prescale);
  assign w_match        = w_tick && (bus.cnt_val == r_compare);
  // Stop wins over a simultaneous start, even outside RUN.
  assign w_start_accept = !w_run && bus.cfg_start && !bus.cfg_stop;
  assign w_stop_accept  = w_run && bus.cfg_stop;

  // Suppress the increment on a stop cycle so the counter holds its value.
  assign bus.cnt_en      = w_tick && !w_match && !w_stop_accept;
  assign bus.cnt_clear   = w_start_accept || w_match;
  assign bus.irq         = r_irq;
  assign bus.irq_overrun = r_overrun;
  assign bus.busy        = w_run;
  assign bus.state       = r_state;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_compare  <= '1;
      r_prescale <= '0;
      r_mode     <= 1'b0;
      r_psc      <= '0;
      r_irq      <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (bus.cfg_we && !w_run) begin
        r_compare  <= bus.cfg_compare;
        r_prescale <= bus.cfg_prescale;
        r_mode     <= bus.cfg_mode;
      end

      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_psc <= '0;
          if (w_start_accept) begin
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_stop_accept) begin
            r_state <= ST_IDLE;
            r_psc   <= '0;
          end else begin
            r_psc <= w_tick ? '0 : (r_psc + PSC_ONE);
            if (w_match && !r_mode) begin
              r_state <= ST_DONE;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_psc   <= '0;
        end
      endcase

      // A match beats a same-cycle ack; overrun looks at the pre-ack level.
      if (w_match) begin
        r_irq <= 1'b1;
        if (r_irq) begin
          r_overrun <= 1'b1;
        end
      end else if (bus.irq_ack) begin
        r_irq     <= 1'b0;
        r_overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl with a behavioural model of the external counter.
module tb_timer_ctrl;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [15:0] r_cnt;

  timer_ctrl_if #(.WIDTH(16), .PRESCALE_WIDTH(8)) bus ();

  timer_ctrl #(.WIDTH(16), .PRESCALE_WIDTH(8)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  // External up-counter: clear has priority over enable, same reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)              r_cnt <= 16'd0;
    else if (bus.cnt_clear) r_cnt <= 16'd0;
    else if (bus.cnt_en)    r_cnt <= r_cnt + 16'd1;
  end
  assign bus.cnt_val = r_cnt;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic configure(input logic [15:0] cmp, input logic [7:0] psc, input logic mode);
    bus.cfg_we = 1'b1; bus.cfg_compare = cmp; bus.cfg_prescale = psc; bus.cfg_mode = mode;
    step();
    bus.cfg_we = 1'b0;
  endtask

  task automatic start();
    bus.cfg_start = 1'b1;
    step();
    bus.cfg_start = 1'b0;
  endtask

  task automatic stop();
    bus.cfg_stop = 1'b1;
    step();
    bus.cfg_stop = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", bus.state); end
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL rst_irq got %b exp 0", bus.irq); end
    checks++; if (bus.irq_overrun !== 1'b0) begin errors++; $display("FAIL rst_ovr got %b exp 0", bus.irq_overrun); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", bus.busy); end
    checks++; if (bus.cnt_en !== 1'b0) begin errors++; $display("FAIL rst_en got %b exp 0", bus.cnt_en); end
    checks++; if (bus.cnt_clear !== 1'b0) begin errors++; $display("FAIL rst_clear got %b exp 0", bus.cnt_clear); end
    step();
    rstn = 1'b1;
    step();
    $display("test_reset done");
  endtask

  task automatic test_oneshot();
    configure(16'd3, 8'd0, 1'b0);
    bus.cfg_start = 1'b1;
    #1;
    checks++; if (bus.cnt_clear !== 1'b1) begin errors++; $display("FAIL os_start_clear got %b exp 1", bus.cnt_clear); end
    step();
    bus.cfg_start = 1'b0;
    checks++; if (bus.state !== 2'd1) begin errors++; $display("FAIL os_state_run got %0d exp 1", bus.state); end
    checks++; if (bus.cnt_val !== 16'd0) begin errors++; $display("FAIL os_cnt0 got %0d exp 0", bus.cnt_val); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL os_busy got %b exp 1", bus.busy); end
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++; if (bus.cnt_val !== 16'(i)) begin errors++; $display("FAIL os_cnt edge %0d got %0d exp %0d", i, bus.cnt_val, i); end
      checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL os_irq_early edge %0d got %b exp 0", i, bus.irq); end
    end
    checks++; if (bus.cnt_clear !== 1'b1) begin errors++; $display("FAIL os_match_clear got %b exp 1", bus.cnt_clear); end
    checks++; if (bus.cnt_en !== 1'b0) begin errors++; $display("FAIL os_match_en got %b exp 0", bus.cnt_en); end
    step();
    checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL os_irq got %b exp 1", bus.irq); end
    checks++; if (bus.state !== 2'd2) begin errors++; $display("FAIL os_state_done got %0d exp 2", bus.state); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL os_busy_done got %b exp 0", bus.busy); end
    checks++; if (bus.cnt_val !== 16'd0) begin errors++; $display("FAIL os_cleared got %0d exp 0", bus.cnt_val); end
    repeat (3) step();
    checks++; if (bus.cnt_en !== 1'b0) begin errors++; $display("FAIL os_en_after got %b exp 0", bus.cnt_en); end
    checks++; if (bus.cnt_val !== 16'd0) begin errors++; $display("FAIL os_cnt_after got %0d exp 0", bus.cnt_val); end
    bus.irq_ack = 1'b1;
    step();
    bus.irq_ack = 1'b0;
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL os_ack got %b exp 0", bus.irq); end
    $display("test_oneshot done");
  endtask

  task automatic test_periodic();
    logic exp_irq, exp_ovr;
    configure(16'd2, 8'd1, 1'b1);
    start();
    for (int e = 1; e <= 19; e++) begin
      bus.irq_ack = (e == 13);
      step();
      bus.irq_ack = 1'b0;
      exp_irq = (e >= 6 && e < 13) || (e >= 18);
      exp_ovr = (e == 12);
      checks++; if (bus.irq !== exp_irq) begin errors++; $display("FAIL per_irq edge %0d got %b exp %b", e, bus.irq, exp_irq); end
      checks++; if (bus.irq_overrun !== exp_ovr) begin errors++; $display("FAIL per_ovr edge %0d got %b exp %b", e, bus.irq_overrun, exp_ovr); end
    end
    stop();
    checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL per_stop got %0d exp 0", bus.state); end
    $display("test_periodic done");
  endtask

  task automatic test_stop_restart();
    bus.irq_ack = 1'b1;
    configure(16'd9, 8'd0, 1'b1);
    bus.irq_ack = 1'b0;
    start();
    repeat (5) step();
    checks++; if (bus.cnt_val !== 16'd5) begin errors++; $display("FAIL sr_cnt5 got %0d exp 5", bus.cnt_val); end
    bus.cfg_stop = 1'b1;
    #1;
    checks++; if (bus.cnt_en !== 1'b0) begin errors++; $display("FAIL sr_stop_en got %b exp 0", bus.cnt_en); end
    step();
    bus.cfg_stop = 1'b0;
    checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL sr_idle got %0d exp 0", bus.state); end
    checks++; if (bus.cnt_val !== 16'd5) begin errors++; $display("FAIL sr_held got %0d exp 5", bus.cnt_val); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL sr_busy got %b exp 0", bus.busy); end
    repeat (2) step();
    checks++; if (bus.cnt_val !== 16'd5) begin errors++; $display("FAIL sr_held2 got %0d exp 5", bus.cnt_val); end
    bus.cfg_start = 1'b1;
    #1;
    checks++; if (bus.cnt_clear !== 1'b1) begin errors++; $display("FAIL sr_restart_clear got %b exp 1", bus.cnt_clear); end
    step();
    bus.cfg_start = 1'b0;
    checks++; if (bus.cnt_val !== 16'd0) begin errors++; $display("FAIL sr_cnt_zero got %0d exp 0", bus.cnt_val); end
    for (int i = 1; i <= 10; i++) begin
      step();
      checks++; if (bus.irq !== (i == 10)) begin errors++; $display("FAIL sr_irq edge %0d got %b exp %b", i, bus.irq, (i == 10)); end
    end
    stop();
    bus.irq_ack = 1'b1;
    step();
    bus.irq_ack = 1'b0;
    $display("test_stop_restart done");
  endtask

  task automatic test_config_lock();
    configure(16'd7, 8'd0, 1'b1);
    start();
    for (int e = 1; e <= 8; e++) begin
      if (e == 1) begin
        bus.cfg_we = 1'b1; bus.cfg_compare = 16'd1;
      end
      step();
      bus.cfg_we = 1'b0;
      checks++; if (bus.irq !== (e == 8)) begin errors++; $display("FAIL lock_run_irq edge %0d got %b exp %b", e, bus.irq, (e == 8)); end
    end
    stop();
    bus.irq_ack = 1'b1;
    configure(16'd7, 8'd0, 1'b0);
    bus.irq_ack = 1'b0;
    start();
    repeat (8) step();
    checks++; if (bus.state !== 2'd2) begin errors++; $display("FAIL lock_done got %0d exp 2", bus.state); end
    bus.irq_ack = 1'b1;
    configure(16'd1, 8'd0, 1'b1);
    bus.irq_ack = 1'b0;
    start();
    for (int e = 1; e <= 4; e++) begin
      bus.irq_ack = (e == 3);
      step();
      bus.irq_ack = 1'b0;
      checks++; if (bus.irq !== (e == 2 || e == 4)) begin errors++; $display("FAIL lock_new_irq edge %0d got %b exp %b", e, bus.irq, (e == 2 || e == 4)); end
    end
    stop();
    bus.irq_ack = 1'b1;
    step();
    bus.irq_ack = 1'b0;
    $display("test_config_lock done");
  endtask

  task automatic test_collisions();
    configure(16'd1, 8'd0, 1'b0);
    start();
    step();
    bus.irq_ack = 1'b1;
    #1;
    checks++; if (bus.cnt_clear !== 1'b1) begin errors++; $display("FAIL col_ack_match got %b exp 1", bus.cnt_clear); end
    step();
    bus.irq_ack = 1'b0;
    checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL col_ack_irq got %b exp 1", bus.irq); end
    checks++; if (bus.irq_overrun !== 1'b0) begin errors++; $display("FAIL col_ack_ovr got %b exp 0", bus.irq_overrun); end
    checks++; if (bus.state !== 2'd2) begin errors++; $display("FAIL col_ack_state got %0d exp 2", bus.state); end

    configure(16'd1, 8'd0, 1'b1);
    start();
    step();
    stop();
    checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL col_stop_state got %0d exp 0", bus.state); end
    checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL col_stop_irq got %b exp 1", bus.irq); end
    checks++; if (bus.irq_overrun !== 1'b1) begin errors++; $display("FAIL col_stop_ovr got %b exp 1", bus.irq_overrun); end
    checks++; if (bus.cnt_val !== 16'd0) begin errors++; $display("FAIL col_stop_cnt got %0d exp 0", bus.cnt_val); end

    bus.irq_ack = 1'b1;
    configure(16'd0, 8'd0, 1'b1);
    bus.irq_ack = 1'b0;
    start();
    step();
    checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL col_cmp0_irq got %b exp 1", bus.irq); end
    checks++; if (bus.irq_overrun !== 1'b0) begin errors++; $display("FAIL col_cmp0_ovr got %b exp 0", bus.irq_overrun); end
    bus.irq_ack = 1'b1;
    step();
    bus.irq_ack = 1'b0;
    checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL col_preack_irq got %b exp 1", bus.irq); end
    checks++; if (bus.irq_overrun !== 1'b1) begin errors++; $display("FAIL col_preack_ovr got %b exp 1", bus.irq_overrun); end
    stop();

    bus.cfg_start = 1'b1; bus.cfg_stop = 1'b1;
    #1;
    checks++; if (bus.cnt_clear !== 1'b0) begin errors++; $display("FAIL col_ss_clear got %b exp 0", bus.cnt_clear); end
    step();
    bus.cfg_start = 1'b0; bus.cfg_stop = 1'b0;
    checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL col_ss_state got %0d exp 0", bus.state); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL col_ss_busy got %b exp 0", bus.busy); end
    $display("test_collisions done");
  endtask

  task automatic test_reset_mid_run();
    configure(16'd9, 8'd0, 1'b1);
    start();
    repeat (4) step();
    checks++; if (bus.cnt_val !== 16'd4) begin errors++; $display("FAIL mr_cnt4 got %0d exp 4", bus.cnt_val); end
    checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL mr_irq_pre got %b exp 1", bus.irq); end
    #3;
    rstn = 1'b0;
    #1;
    checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL mr_state got %0d exp 0", bus.state); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mr_busy got %b exp 0", bus.busy); end
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL mr_irq got %b exp 0", bus.irq); end
    checks++; if (bus.irq_overrun !== 1'b0) begin errors++; $display("FAIL mr_ovr got %b exp 0", bus.irq_overrun); end
    checks++; if (bus.cnt_en !== 1'b0) begin errors++; $display("FAIL mr_en got %b exp 0", bus.cnt_en); end
    checks++; if (bus.cnt_clear !== 1'b0) begin errors++; $display("FAIL mr_clear got %b exp 0", bus.cnt_clear); end
    checks++; if (bus.cnt_val !== 16'd0) begin errors++; $display("FAIL mr_cnt got %0d exp 0", bus.cnt_val); end
    #1;
    rstn = 1'b1;
    repeat (3) step();
    checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL mr_stay_idle got %0d exp 0", bus.state); end
    checks++; if (bus.cnt_en !== 1'b0) begin errors++; $display("FAIL mr_stay_en got %b exp 0", bus.cnt_en); end
    // Reset config: compare all ones, so no match within a few ticks.
    start();
    repeat (5) step();
    checks++; if (bus.cnt_val !== 16'd5) begin errors++; $display("FAIL mr_cfg_cnt got %0d exp 5", bus.cnt_val); end
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL mr_cfg_irq got %b exp 0", bus.irq); end
    stop();
    $display("test_reset_mid_run done");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cfg_we = 1'b0; bus.cfg_compare = 16'd0; bus.cfg_prescale = 8'd0; bus.cfg_mode = 1'b0;
    bus.cfg_start = 1'b0; bus.cfg_stop = 1'b0; bus.irq_ack = 1'b0;
    test_reset();
    test_oneshot();
    test_periodic();
    test_stop_restart();
    test_config_lock();
    test_collisions();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_ctrl.md
# timer_ctrl

Programmable interval-timer controller that sequences an external up-counter (increment rate 1, synchronous clear with priority over enable) to generate one-shot or periodic timer interrupts for the RV32I core. It owns a prescaler, a compare register and a small state machine, and drives the counter's `en`/`clear` inputs. It observes the counter's value and raises a level interrupt with overrun detection toward the interrupt logic.

## Interface
Parameters:
- `WIDTH`, 16: counter/compare width; must match the attached counter.
- `PRESCALE_WIDTH`, 8: prescaler width.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `cfg_we`  in  1  load `cfg_compare`, `cfg_prescale`, `cfg_mode` into the config registers.
- `cfg_compare`  in  WIDTH  terminal count.
- `cfg_prescale`  in  PRESCALE_WIDTH  prescale value P; one counter tick per P+1 cycles.
- `cfg_mode`  in  1  0 = one-shot, 1 = periodic.
- `cfg_start`  in  1  start request pulse.
- `cfg_stop`  in  1  stop request pulse.
- `irq_ack`  in  1  clear pending interrupt and overrun.
- `cnt_val`  in  WIDTH  current counter value.
- `cnt_en`  out  1  counter increment enable (combinational).
- `cnt_clear`  out  1  counter synchronous clear (combinational).
- `irq`  out  1  interrupt pending (registered level).
- `irq_overrun`  out  1  sticky: a match occurred while `irq` was already set.
- `busy`  out  1  high in RUN.
- `state`  out  2  IDLE=0, RUN=1, DONE=2.

## Operation
- Config registers reset to compare = all ones, prescale = 0, mode = 0.
- `cfg_we` is accepted in IDLE and DONE only. In RUN it is ignored and the registers keep their values.
- Prescaler `psc` counts 0..P in RUN only. `tick = (state==RUN) && (psc==P)`. On `tick`, `psc` returns to 0; otherwise it increments.
- `match = tick && (cnt_val == compare)`.
- `cnt_en = tick && !match`.
- `cnt_clear = start_accept || match`.
- State transitions:
  - IDLE/DONE, `cfg_start`: `start_accept`; `psc` is set to 0; go to RUN.
  - RUN, `cfg_stop`: go to IDLE. The counter value is held, not cleared, and `psc` is set to 0.
  - RUN, `match`, mode 0: go to DONE.
  - RUN, `match`, mode 1: stay in RUN. The counter clears and the period restarts.
- `cfg_stop` has priority over `cfg_start` and over `match`. The state-transition effect of a match is suppressed, but its `cnt_clear`/irq effects still occur that cycle.
- `cfg_start` in RUN is ignored.
- `cfg_stop` in IDLE/DONE is ignored.
- Interrupt:
  - On `match`: `irq` is set to 1; if `irq` was already 1, `irq_overrun` is set to 1.
  - On `irq_ack`: both are cleared.
  - Set wins over ack in the same cycle; overrun is then evaluated against the pre-ack `irq`.
- Compare = 0 is legal: match occurs on every tick.

## Timing
- Reset values:
  - state IDLE, `psc` 0, `irq` 0, `irq_overrun` 0, `busy` 0.
  - `cnt_en` 0, `cnt_clear` 0.
- Start latency:
  - `cfg_start` sampled at edge k; `cnt_clear` is high in cycle k-1..k.
  - The first RUN cycle begins at edge k, with `cnt_val` = 0 and `psc` = 0.
- First tick: P cycles after entering RUN, or in the same cycle if P = 0.
- Period: the interval from RUN entry to the edge setting `irq` is (compare+1)·(P+1) cycles. Each `cnt_val` is held P+1 cycles.
- `irq` rises at the edge ending the match cycle; it is 1 cycle after the combinational `match`.
- Periodic mode: matches are spaced exactly (compare+1)·(P+1) cycles, with no dead cycle.
- Asynchronous reset mid-RUN: immediate return to all reset values. The counter is reset by the same `rstn`.
- `cnt_val` width overflow cannot occur, since clear happens at compare ≤ 2^WIDTH−1.

## Test plan
- One-shot, compare=3, P=0, start at edge 0:
  - `cnt_val` 0,1,2,3, then cleared.
  - `irq`=1 after edge 4; state DONE; `busy`=0; `cnt_en` stays 0 afterwards.
- Periodic, compare=2, P=1:
  - `irq` sets at edges 6, 12, 18.
  - Without ack, `irq_overrun`=1 from edge 12.
  - `irq_ack` at edge 13 clears both; `irq` sets again at 18.
- Stop/restart:
  - Periodic compare=9, P=0; `cfg_stop` at `cnt_val`=5 gives IDLE with `cnt_val` held at 5.
  - `cfg_start` clears `cnt_val` to 0; next `irq` is 10 cycles later.
- Config lock:
  - `cfg_we` with compare=1 during RUN (compare=7) is ignored and `irq` follows the 8-cycle period.
  - The same write in DONE takes effect on the next start (2-cycle period).
- Collisions:
  - `irq_ack` in the match cycle leaves `irq`=1.
  - `cfg_stop` in the match cycle gives IDLE, `irq`=1, counter cleared.
  - `cfg_start` and `cfg_stop` together in IDLE give no start.
- Reset mid-RUN:
  - `rstn` low asynchronously at `cnt_val`=4 forces all outputs to reset values before the next edge.
  - After release, state stays IDLE until `cfg_start`.
